// File: rtl/adder_283.sv
// 4-bit carry-lookahead adder (74xx283 style) with a registered copy of the result.
// Define ADDER_283_FLAGS_EN to add zero/overflow flags and their registered copies.
module adder_283 #(
    parameter logic [4:0] RST_VAL = 5'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  tri1        en,
    output logic [3:0] s,
    output logic       cout,
    output logic [3:0] s_q,
    output logic       cout_q
`ifdef ADDER_283_FLAGS_EN
    ,
    output logic       zero,
    output logic       ovf,
    output logic       zero_q,
    output logic       ovf_q
`endif
);

    localparam int unsigned W = 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic [W:0]   res_d;
    logic [W:0]   res_q;

    // Generate/propagate lookahead: every carry is a flat sum of products of g, p and cin.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[W-1:0];
        cout = c[W];
    end

    always_comb begin
        res_d = res_q;
        if (en) begin
            res_d = {cout, s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= RST_VAL;
        end else begin
            res_q <= res_d;
        end
    end

    assign s_q    = res_q[W-1:0];
    assign cout_q = res_q[W];

`ifdef ADDER_283_FLAGS_EN
    logic [1:0] flag_d;
    logic [1:0] flag_q;

    // Signed overflow: operands share a sign that the sum does not.
    always_comb begin
        zero   = (s == 4'h0);
        ovf    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        flag_d = flag_q;
        if (en) begin
            flag_d = {ovf, zero};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 2'b00;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign zero_q = flag_q[0];
    assign ovf_q  = flag_q[1];
`endif

endmodule

// File: tb/tb_adder_283.sv
// Bench for adder_283: exhaustive combinational sweep, directed register cases,
// randomized registered traffic checked through a scoreboard queue.
module tb_adder_283;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cin;
    logic [3:0] a;
    logic [3:0] b;
    wire  [3:0] s;
    wire        cout;
    wire  [3:0] s_q;
    wire        cout_q;
    wire  [6:0] act_reg;
    wire  [6:0] act_comb;

`ifdef ADDER_283_FLAGS_EN
    wire zero, ovf, zero_q, ovf_q;
    assign act_reg  = {ovf_q, zero_q, cout_q, s_q};
    assign act_comb = {ovf, zero, cout, s};
`else
    assign act_reg  = {2'b00, cout_q, s_q};
    assign act_comb = {2'b00, cout, s};
`endif

    adder_283 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .en     (en),
        .s      (s),
        .cout   (cout),
        .s_q    (s_q),
        .cout_q (cout_q)
`ifdef ADDER_283_FLAGS_EN
        ,
        .zero   (zero),
        .ovf    (ovf),
        .zero_q (zero_q),
        .ovf_q  (ovf_q)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] exp_q[$];
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; flags only when the feature is built in.
    function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y, input logic ci);
        int sum;
        int ssum;
        logic z;
        logic o;
        sum  = int'(x) + int'(y) + int'(ci);
        ssum = int'($signed(x)) + int'($signed(y)) + int'(ci);
        z    = ((sum % 16) == 0);
        o    = (ssum > 7) || (ssum < -8);
`ifdef ADDER_283_FLAGS_EN
        return {o, z, 5'(sum)};
`else
        return {2'b00, 5'(sum)};
`endif
    endfunction

    // Monitor: the registered result is presented every clock while traffic runs.
    always @(posedge clk) begin
        if (mon_en) begin
            logic [6:0] e;
            #1;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("reg_result", 32'(act_reg), 32'(e));
            end
        end
    end

    initial begin
        logic [6:0] mreg;
        a = 4'h0; b = 4'h0; cin = 1'b0; en = 1'b1; rst_n = 1'b0;
        #2;
        check("reset_state", 32'(act_reg), 32'h0);

        for (int ci = 0; ci < 2; ci++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ai = 0; ai < 16; ai++) begin
                    a = 4'(ai); b = 4'(bi); cin = 1'(ci);
                    #1;
                    check("comb_sweep", 32'(act_comb), 32'(model(a, b, cin)));
                end
            end
        end

        @(negedge clk);
        rst_n = 1'b1;
        a = 4'h9; b = 4'h8; cin = 1'b1; en = 1'b1;
        #1;
        check("dir_9_8_1_comb", 32'({cout, s}), 32'h12);
        @(posedge clk); #1;
        check("dir_9_8_1_reg", 32'({cout_q, s_q}), 32'h12);

        @(negedge clk);
        en = 1'b0; a = 4'h1; b = 4'h1; cin = 1'b0;
        #1;
        check("hold_comb", 32'({cout, s}), 32'h02);
        @(posedge clk); #1;
        check("hold_reg_1", 32'({cout_q, s_q}), 32'h12);
        @(posedge clk); #1;
        check("hold_reg_2", 32'({cout_q, s_q}), 32'h12);

        // Flags reflect the held 9+8+1 capture, not the current inputs.
        mreg = model(4'h9, 4'h8, 1'b1);
        check("hold_reg_full", 32'(act_reg), 32'(mreg));

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a   = 4'($urandom_range(15, 0));
            b   = 4'($urandom_range(15, 0));
            cin = 1'($urandom_range(1, 0));
            en  = ($urandom_range(3, 0) != 0);
            if (i % 50 == 0) begin
                a = 4'hF; b = (i % 100 == 0) ? 4'hF : 4'h0; cin = 1'b1;
            end
            if (en) mreg = model(a, b, cin);
            exp_q.push_back(mreg);
            mon_en = 1'b1;
            #1;
            check("rand_comb", 32'(act_comb), 32'(model(a, b, cin)));
        end
        @(posedge clk); #2;
        mon_en = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef ADDER_283_FLAGS_EN
        @(negedge clk);
        a = 4'h7; b = 4'h1; cin = 1'b0; en = 1'b1;
        #1;
        check("flags_7_1", 32'({s, ovf, zero}), 32'({4'h8, 1'b1, 1'b0}));
        a = 4'h8; b = 4'h8;
        #1;
        check("flags_8_8", 32'({s, cout, zero, ovf}), 32'({4'h0, 1'b1, 1'b1, 1'b1}));
`endif

        @(negedge clk);
        a = 4'hF; b = 4'hF; cin = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        check("max_reg", 32'({cout_q, s_q}), 32'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(act_reg), 32'h0);
        check("reset_comb_intact", 32'({cout, s}), 32'h1F);
        @(posedge clk); #1;
        check("reset_over_en", 32'(act_reg), 32'h0);

        @(negedge clk);
        rst_n = 1'b1; a = 4'hF; b = 4'h0; cin = 1'b1;
        #1;
        check("wrap_comb", 32'({cout, s}), 32'h10);
        check("no_capture_before_edge", 32'(act_reg), 32'h0);
        @(posedge clk); #1;
        check("first_capture", 32'(act_reg), 32'(model(4'hF, 4'h0, 1'b1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_283.md
ADDER_283 -- requirements
Module: adder_283

Interface
REQ-001 Parameter RST_VAL, default 5'h00: value loaded into {cout_q, s_q} on reset.
REQ-002 clk  input  1  clock; rising edge samples the registered result.
REQ-003 rst_n  input  1  reset, asynchronous, active-low; affects registered outputs only.
REQ-004 a  input  4  addend A (unsigned, bit 0 = LSB).
REQ-005 b  input  4  addend B (unsigned, bit 0 = LSB).
REQ-006 cin  input  1  carry into bit 0.
REQ-007 en  input  1  capture enable for the registered outputs; an unconnected en SHALL read as 1 (pull-up default).
REQ-008 s  output  4  combinational sum bits, a+b+cin modulo 16.
REQ-009 cout  output  1  combinational carry out of bit 3.
REQ-010 s_q  output  4  registered copy of s.
REQ-011 cout_q  output  1  registered copy of cout.
REQ-012 One clock (clk); reset asynchronous active-low (rst_n); both fixed.

Function
REQ-013 {cout, s} SHALL equal a + b + cin as a 5-bit unsigned sum for all 512 input combinations.
REQ-014 s/cout SHALL be purely combinational with zero clock latency; valid within one time unit of any input change.
REQ-015 s/cout SHALL NOT depend on clk, rst_n or en, and SHALL be correct with those ports left unconnected.
REQ-016 Carry SHALL be computed with 4-bit carry-lookahead (per-bit generate a&b, propagate a^b), matching the 74xx283 structure; no ripple through sum bits.
REQ-017 Boundary: 15+15+1 -> s=4'hF, cout=1; 0+0+0 -> s=0, cout=0; 15+0+1 -> s=0, cout=1 (wrap-around).
REQ-018 On each rising clk with rst_n=1 and en=1, {cout_q, s_q} SHALL load {cout, s}; latency exactly one cycle.
REQ-019 With en=0, {cout_q, s_q} SHALL hold their value.
REQ-020 No X/Z propagation into s/cout when a, b, cin are known.

Reset
REQ-021 rst_n low SHALL immediately (asynchronously) force {cout_q, s_q} to RST_VAL regardless of clk.
REQ-022 Release of rst_n SHALL take effect at the next rising clk; the first capture occurs on that edge.
REQ-023 Reset asserted mid-operation SHALL override en and any pending capture; combinational s/cout are unaffected.

Configuration
REQ-024 Macro ADDER_283_FLAGS_EN defined: add outputs zero (1 when s==0), ovf (signed two's-complement overflow: a[3]==b[3] and s[3]!=a[3]), and registered zero_q/ovf_q captured per REQ-018, reset to 0.
REQ-025 Macro ADDER_283_FLAGS_EN undefined: flag ports and logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-026 Exhaustive: cin 0..1, b 0..15, a 0..15, wait 1 time unit -> s==(a+b+cin)[3:0], cout==(a+b+cin)[4]; clk/rst_n unconnected.
REQ-027 a=4'h9, b=4'h8, cin=1 -> s=4'h2, cout=1; after one rising clk with en=1 -> s_q=4'h2, cout_q=1.
REQ-028 Registered s_q=4'h2, then en=0, inputs a=1,b=1,cin=0, clock twice -> s_q stays 4'h2 while s=4'h2 combinationally reflects new inputs.
REQ-029 Drive rst_n=0 between clock edges -> s_q=0, cout_q=0 immediately (RST_VAL default); s/cout unchanged.
REQ-030 With ADDER_283_FLAGS_EN: a=7, b=1, cin=0 -> s=8, ovf=1, zero=0; a=8, b=8, cin=0 -> s=0, cout=1, zero=1, ovf=1.
